// File: rtl/fix_loc_pkg.sv
// Shared types and reset constants for the FIX field locator table.
// Build option: define FIELD_LEN_EN to add the rd_len_o port on field_loc_table.
package fix_loc_pkg;

    localparam int LOC_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        FULL = 2'd2
    } loc_state_t;

    // Default entry layout; the top re-derives it at its own IDX_WIDTH.
    typedef struct packed {
        logic [LOC_IDX_W-1:0] start_idx;
        logic [LOC_IDX_W-1:0] end_idx;
    } loc_entry_t;

    localparam loc_state_t LOC_STATE_RST = IDLE;
    localparam logic       LOC_FLAG_RST  = 1'b0;

endpackage

// File: rtl/loc_slot_ram.sv
// Slot array for field_loc_table: one write, one registered read, per-slot valid bits.
// A read of the slot being written in the same cycle returns the old contents.
module loc_slot_ram
    import fix_loc_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = loc_entry_t,
    localparam int SLOT_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              we,
    input  logic [SLOT_W-1:0] wr_slot,
    input  entry_t            wr_data,
    input  logic              rd_req,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic              rd_valid,
    output logic              rd_hit,
    output entry_t            rd_data
);

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_slot] <= 1'b1;
        end
    end

    // Payload needs no reset; the valid bits gate every observation of it.
    always_ff @(posedge clk) begin
        if (we) mem[wr_slot] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            rd_hit   <= rd_req & valid[rd_slot];
            if (rd_req) rd_data <= valid[rd_slot] ? mem[rd_slot] : '0;
        end
    end

endmodule

// File: rtl/field_loc_table.sv
// Per-message (start, end) field locator: open/close capture, validation, slot lookup.
// Build option: FIELD_LEN_EN adds rd_len_o = end - start + 1 on hits.
module field_loc_table
    import fix_loc_pkg::*;
#(
    parameter int  IDX_WIDTH = 5,
    parameter int  DEPTH     = 16,
    localparam int SLOT_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 open_i,
    input  logic [IDX_WIDTH-1:0] start_i,
    input  logic                 close_i,
    input  logic [IDX_WIDTH-1:0] end_i,
    input  logic                 rd_req_i,
    input  logic [SLOT_W-1:0]    rd_slot_i,
    output logic                 rd_valid_o,
    output logic                 rd_hit_o,
    output logic [IDX_WIDTH-1:0] rd_start_o,
    output logic [IDX_WIDTH-1:0] rd_end_o,
`ifdef FIELD_LEN_EN
    output logic [IDX_WIDTH:0]   rd_len_o,
`endif
    output logic [SLOT_W:0]      field_count_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 err_o
);

    typedef struct packed {
        logic [IDX_WIDTH-1:0] start_idx;
        logic [IDX_WIDTH-1:0] end_idx;
    } entry_t;

    localparam logic [SLOT_W:0] LAST_SLOT = (SLOT_W+1)'(DEPTH - 1);

    loc_state_t           state, nxt_state;
    logic [IDX_WIDTH-1:0] pend, nxt_pend;
    entry_t               cm, rd_data;
    logic                 do_commit, bad, we, set_err, set_ovf;

    always_comb begin
        nxt_state = state;
        nxt_pend  = pend;
        do_commit = 1'b0;
        cm        = '0;
        set_err   = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            IDLE: begin
                if (open_i && close_i) begin
                    do_commit = 1'b1;
                    cm        = '{start_idx: start_i, end_idx: end_i};
                end else if (open_i) begin
                    nxt_pend  = start_i;
                    nxt_state = OPEN;
                end else if (close_i) begin
                    set_err = 1'b1;
                end
            end
            OPEN: begin
                if (close_i) begin
                    do_commit = 1'b1;
                    cm        = '{start_idx: pend, end_idx: end_i};
                    if (open_i) nxt_pend  = start_i;
                    else        nxt_state = IDLE;
                end else if (open_i) begin
                    nxt_pend = start_i;
                    set_err  = 1'b1;
                end
            end
            FULL: begin
                if (open_i) set_ovf = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
        bad = do_commit && (cm.end_idx < cm.start_idx);
        we  = do_commit && !bad;
        if (bad) set_err = 1'b1;
        // The last free slot being filled wins over a same-cycle reopen.
        if (we && field_count_o == LAST_SLOT) nxt_state = FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LOC_STATE_RST;
            pend          <= '0;
            field_count_o <= '0;
            busy_o        <= LOC_FLAG_RST;
            overflow_o    <= LOC_FLAG_RST;
            err_o         <= LOC_FLAG_RST;
        end else if (clear_i) begin
            state         <= LOC_STATE_RST;
            pend          <= '0;
            field_count_o <= '0;
            busy_o        <= LOC_FLAG_RST;
            overflow_o    <= LOC_FLAG_RST;
            err_o         <= LOC_FLAG_RST;
        end else begin
            state      <= nxt_state;
            pend       <= nxt_pend;
            busy_o     <= (nxt_state == OPEN);
            overflow_o <= overflow_o | set_ovf;
            err_o      <= err_o | set_err;
            if (we) field_count_o <= field_count_o + 1'b1;
        end
    end

    loc_slot_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_i),
        .we       (we && !clear_i),
        .wr_slot  (field_count_o[SLOT_W-1:0]),
        .wr_data  (cm),
        .rd_req   (rd_req_i),
        .rd_slot  (rd_slot_i),
        .rd_valid (rd_valid_o),
        .rd_hit   (rd_hit_o),
        .rd_data  (rd_data)
    );

    assign rd_start_o = rd_data.start_idx;
    assign rd_end_o   = rd_data.end_idx;

`ifdef FIELD_LEN_EN
    // Derived from the registered read word, so it changes on the same edge.
    assign rd_len_o = rd_hit_o
        ? ({1'b0, rd_data.end_idx} - {1'b0, rd_data.start_idx} + (IDX_WIDTH+1)'(1))
        : '0;
`endif

endmodule

// File: tb/tb_field_loc_table.sv
// Scoreboard bench for field_loc_table (DEPTH=4): reads queue expectations, a monitor checks them.
module tb_field_loc_table;

    logic       clk = 1'b0;
    logic       rst, clear_i, open_i, close_i, rd_req_i;
    logic [4:0] start_i, end_i;
    logic [1:0] rd_slot_i;
    logic       rd_valid_o, rd_hit_o, busy_o, overflow_o, err_o;
    logic [4:0] rd_start_o, rd_end_o;
    logic [2:0] field_count_o;
`ifdef FIELD_LEN_EN
    logic [5:0] rd_len_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       hit;
        logic [4:0] s;
        logic [4:0] e;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    field_loc_table #(.IDX_WIDTH(5), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear_i),
        .open_i        (open_i),
        .start_i       (start_i),
        .close_i       (close_i),
        .end_i         (end_i),
        .rd_req_i      (rd_req_i),
        .rd_slot_i     (rd_slot_i),
        .rd_valid_o    (rd_valid_o),
        .rd_hit_o      (rd_hit_o),
        .rd_start_o    (rd_start_o),
        .rd_end_o      (rd_end_o),
`ifdef FIELD_LEN_EN
        .rd_len_o      (rd_len_o),
`endif
        .field_count_o (field_count_o),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o),
        .err_o         (err_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Apply the staged inputs at the next edge, then return the bus to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        open_i   = 1'b0;
        close_i  = 1'b0;
        clear_i  = 1'b0;
        rd_req_i = 1'b0;
    endtask

    task automatic rd(input int slot, input logic hit, input int s, input int e);
        rd_req_i  = 1'b1;
        rd_slot_i = 2'(slot);
        q.push_back('{hit, 5'(s), 5'(e)});
    endtask

    task automatic op(input logic o, input int s, input logic c, input int e);
        open_i  = o;
        start_i = 5'(s);
        close_i = c;
        end_i   = 5'(e);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_rd_valid", 1, 0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("rd_hit", int'(rd_hit_o), int'(x.hit));
                if (x.hit) begin
                    chk("rd_start", int'(rd_start_o), int'(x.s));
                    chk("rd_end", int'(rd_end_o), int'(x.e));
`ifdef FIELD_LEN_EN
                    chk("rd_len", int'(rd_len_o), int'(x.e) - int'(x.s) + 1);
`endif
                end
`ifdef FIELD_LEN_EN
                else chk("rd_len_miss", int'(rd_len_o), 0);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; clear_i = 0; open_i = 0; close_i = 0; rd_req_i = 0;
        start_i = 0; end_i = 0; rd_slot_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", int'(rd_valid_o), 0);
        chk("rst_rd_hit", int'(rd_hit_o), 0);
        chk("rst_rd_start", int'(rd_start_o), 0);
        chk("rst_rd_end", int'(rd_end_o), 0);
        chk("rst_count", int'(field_count_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_err", int'(err_o), 0);
        rst = 1'b0;
        tick();

        // basic open then close
        op(1, 3, 0, 0); tick();
        chk("t1_busy_open", int'(busy_o), 1);
        op(0, 0, 1, 7); tick();
        chk("t1_busy_closed", int'(busy_o), 0);
        chk("t1_count", int'(field_count_o), 1);
        rd(0, 1, 3, 7); tick();
        tick();

        // same-cycle open+close in IDLE, then close+reopen in OPEN
        do_clear();
        op(1, 2, 1, 4); tick();
        chk("t2_count1", int'(field_count_o), 1);
        chk("t2_busy_idle", int'(busy_o), 0);
        op(1, 6, 0, 0); tick();
        op(1, 11, 1, 9); tick();
        chk("t2_count2", int'(field_count_o), 2);
        chk("t2_busy_reopen", int'(busy_o), 1);
        rd(0, 1, 2, 4); tick();
        rd(1, 1, 6, 9); tick();
        op(0, 0, 1, 12); tick();
        chk("t2_count3", int'(field_count_o), 3);
        rd(2, 1, 11, 12); tick();
        tick();

        // end < start rejected; close in IDLE flagged
        do_clear();
        op(1, 5, 0, 0); tick();
        op(0, 0, 1, 1); tick();
        chk("t3_err", int'(err_o), 1);
        chk("t3_count", int'(field_count_o), 0);
        chk("t3_busy", int'(busy_o), 0);
        rd(0, 0, 0, 0); tick();
        do_clear();
        chk("t3_err_cleared", int'(err_o), 0);
        op(0, 0, 1, 3); tick();
        chk("t3_err_idle_close", int'(err_o), 1);
        chk("t3_count_idle_close", int'(field_count_o), 0);

        // fill to DEPTH, overflow, clear
        do_clear();
        for (int i = 0; i < 4; i++) begin
            op(1, 2*i+1, 1, 2*i+2); tick();
        end
        chk("t4_count_full", int'(field_count_o), 4);
        op(1, 9, 0, 0); tick();
        chk("t4_ovf", int'(overflow_o), 1);
        chk("t4_busy_full", int'(busy_o), 0);
        op(0, 0, 1, 10); tick();
        chk("t4_count_held", int'(field_count_o), 4);
        chk("t4_err_none", int'(err_o), 0);
        rd(3, 1, 7, 8); tick();
        do_clear();
        chk("t4_count_clr", int'(field_count_o), 0);
        chk("t4_ovf_clr", int'(overflow_o), 0);
        rd(0, 0, 0, 0); tick();

        // read-before-write on the slot being committed
        do_clear();
        op(1, 1, 1, 2); tick();
        op(1, 3, 0, 0); tick();
        op(0, 0, 1, 5); rd(1, 0, 0, 0); tick();
        rd(1, 1, 3, 5); tick();
        tick();

        // reset mid-field drops the pending open
        do_clear();
        op(1, 10, 0, 0); tick();
        rst = 1'b1; #2;
        chk("t6_busy_rst", int'(busy_o), 0);
        chk("t6_rd_valid_rst", int'(rd_valid_o), 0);
        tick();
        rst = 1'b0; tick();
        op(0, 0, 1, 14); tick();
        chk("t6_count_no_commit", int'(field_count_o), 0);
        chk("t6_err_close", int'(err_o), 1);
        rd(0, 0, 0, 0); tick();
        op(1, 10, 1, 14); tick();
        rd(0, 1, 10, 14); tick();
        tick();
        tick();

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/field_loc_table.md
# field_loc_table

Parametrised per-message field locator for the FIX parser, the next generation of the start/end index store. It records one (start, end) byte-index pair per parsed field in arrival order, using an open/close handshake. It validates each pair and tracks occupancy, overflow and protocol errors. It serves registered lookups by slot number to the tag/value extraction stage, and is cleared per message.

## Interface
- IDX_WIDTH, 5, width of a byte index within the message buffer
- DEPTH, 16, number of field slots; power of two, ≥2
- SLOT_W, $clog2(DEPTH), slot address width (derived, not overridden)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clear_i  in  1  discard all slots and pending open (start of new message)
- open_i  in  1  field begins; start_i captured
- start_i  in  IDX_WIDTH  start index of field
- close_i  in  1  field ends; end_i captured
- end_i  in  IDX_WIDTH  end index of field (inclusive)
- rd_req_i  in  1  lookup request
- rd_slot_i  in  SLOT_W  slot to read
- rd_valid_o  out  1  lookup result valid (one cycle)
- rd_hit_o  out  1  slot holds a committed field
- rd_start_o  out  IDX_WIDTH  stored start
- rd_end_o  out  IDX_WIDTH  stored end
- field_count_o  out  SLOT_W+1  committed fields, 0..DEPTH
- busy_o  out  1  a field is open (state OPEN)
- overflow_o  out  1  sticky: open attempted while full
- err_o  out  1  sticky: close without open, or end < start

## Operation
- State machine (`loc_state_t`): IDLE, OPEN, FULL.
  - IDLE: `open_i` latches `start_i` into the pending register and moves to OPEN.
    - `open_i & close_i` in the same cycle commits (`start_i`, `end_i`) directly and stays in IDLE.
    - `close_i` alone sets `err_o`; nothing is written.
  - OPEN: `close_i` commits (pending start, `end_i`) to slot `field_count_o` and increments the count.
    - `close_i & open_i` commits, then latches the new `start_i`; state stays OPEN.
    - `open_i` alone overwrites the pending start and sets `err_o`.
  - FULL: entered whenever the count reaches DEPTH after a commit. `open_i` sets `overflow_o` and is otherwise ignored. `close_i` is ignored.
- Commit check: if end < start (unsigned), the commit is dropped. `err_o` is set, the count is unchanged, and the pending field is discarded.
- Slot valid bit is set on commit. The valid bits, count, pending register, state, `err_o` and `overflow_o` all clear on `clear_i`.
- `clear_i` has priority over every other input in the same cycle. The table is empty and the state is IDLE on the next cycle.
- Read of a slot being committed in the same cycle returns the pre-write contents and hit (read-before-write).
- Read of a slot ≥ `field_count_o` returns `rd_hit_o`=0. Its start/end values are don't-care; the bench checks them only when hit=1.

## Timing
- Read latency 1: `rd_req_i` at cycle N gives `rd_valid_o`=1 plus data at N+1. `rd_valid_o` is a single-cycle pulse per request; back-to-back requests are allowed every cycle.
- Commit is visible to a read issued the cycle after the commit edge. `field_count_o` updates at that same edge.
- Reset values: `rd_valid_o`=0, `rd_hit_o`=0, `rd_start_o`=0, `rd_end_o`=0, `field_count_o`=0, `busy_o`=0, `overflow_o`=0, `err_o`=0; state IDLE; all valid bits 0.
- Reset asserted mid-field drops the pending open with no commit.
- `busy_o` equals (state==OPEN), registered.

## Configuration
- FIELD_LEN_EN defined: adds output `rd_len_o` [IDX_WIDTH:0] = end − start + 1. It is registered with the other read outputs and is 0 when hit=0 or in reset.
- FIELD_LEN_EN undefined: port and subtractor absent; all other behaviour identical.

## Structure
- Package `fix_loc_pkg`: `loc_state_t` enum, `loc_entry_t` packed struct {start, end} parameterised through localparam defaults, and the reset-value constants.
- Sub-module `loc_slot_ram`: 1-write/1-read synchronous slot array of `loc_entry_t` with a per-slot valid vector, `clear` input and read-before-write. It holds the valid bits and read data; the top owns the FSM, count, checks and flags.

## Test plan
- Reset then open(start=3), close(end=7), read slot 0 → `rd_valid_o`=1 next cycle, hit=1, start=3, end=7, `field_count_o`=1, `busy_o` 1→0.
- Same-cycle open(2)+close(4) in IDLE, then in OPEN close(9)+open(11) → slots hold (2,4) and (prev start,9); `busy_o`=1 with pending start 11; count=2.
- Close(end=1) after open(start=5) → `err_o`=1, count unchanged, slot unwritten (hit=0); close in IDLE also sets `err_o`.
- DEPTH=4: commit 4 fields, then open → state FULL, `overflow_o`=1, count=4, slot 3 intact; `clear_i` → count=0, flags 0, read slot 0 hit=0.
- Read slot 1 in the same cycle as its commit → hit=0; repeat the read next cycle → hit=1 with the new data.
- FIELD_LEN_EN build: field (10,14) → `rd_len_o`=5; assert `rst` mid-field → all outputs 0 and no commit.
